// File: rtl/gpr_wb_arbiter.sv
// Write-back arbiter: three requesters (ALU, LSU, MDU) compete for register-file write port C.
// Round-robin or fixed-priority selection. The winner's write is registered with one cycle of latency.
module gpr_wb_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic [2:0]  req_valid,
  input  logic [4:0]  req_addr0,
  input  logic [4:0]  req_addr1,
  input  logic [4:0]  req_addr2,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  input  logic [31:0] req_data2,
  output logic [2:0]  req_ready,
  output logic        wren,
  output logic [4:0]  addrC,
  output logic [31:0] data_in_C,
  output logic [1:0]  grant_id,
  output logic [15:0] wb_count
);

  logic [1:0]  r_ptr;
  logic        r_wren;
  logic [4:0]  r_addr;
  logic [31:0] r_data;
  logic [1:0]  r_gid;
  logic [15:0] r_cnt;

  logic [2:0]  w_rot;
  logic        w_gnt_vld;
  logic [1:0]  w_gnt_id;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // w_rot[j] is the valid bit of requester (ptr + j) mod 3, so bit 0 is searched first.
  always_comb begin
    case (r_ptr)
      2'd1:    w_rot = {req_valid[0], req_valid[2:1]};
      2'd2:    w_rot = {req_valid[1:0], req_valid[2]};
      default: w_rot = req_valid;
    endcase
  end

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 2'd0;
    if (!hold && !rst) begin
      for (int j = 2; j >= 0; j--) begin
        if (w_rot[j]) begin
          w_gnt_vld = 1'b1;
          w_gnt_id  = add_mod3(r_ptr, j[1:0]);
        end
      end
    end
  end

  always_comb begin
    w_addr = req_addr0;
    w_data = req_data0;
    case (w_gnt_id)
      2'd1: begin
        w_addr = req_addr1;
        w_data = req_data1;
      end
      2'd2: begin
        w_addr = req_addr2;
        w_data = req_data2;
      end
      default: ;
    endcase
  end

  assign req_ready = w_gnt_vld ? (3'b001 << w_gnt_id) : 3'b000;

  // Writes to r0 are accepted and consume a slot, but never raise wren.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= 2'd0;
      r_wren <= 1'b0;
      r_addr <= 5'd0;
      r_data <= 32'd0;
      r_gid  <= 2'd0;
      r_cnt  <= 16'd0;
    end else begin
      r_cnt <= r_cnt + {15'd0, r_wren};
      if (w_gnt_vld) begin
        r_wren <= (w_addr != 5'd0);
        r_addr <= w_addr;
        r_data <= w_data;
        r_gid  <= w_gnt_id;
        if (RR_EN != 0) r_ptr <= add_mod3(w_gnt_id, 2'd1);
      end else begin
        r_wren <= 1'b0;
      end
    end
  end

  assign wren      = r_wren;
  assign addrC     = r_addr;
  assign data_in_C = r_data;
  assign grant_id  = r_gid;
  assign wb_count  = r_cnt;

endmodule
